// File: rtl/exe_mem_skid_pkg.sv
// Types and constants shared by the execute and memory stages: widths, branch-kind bit
// positions in bj_info/bj_data, and the payload bundle carried across the boundary.
package exe_mem_skid_pkg;

  localparam int XLEN  = 64;
  localparam int BJ_W  = 8;
  localparam int MEM_W = 8;

  localparam int BJ_BEQ  = 0;
  localparam int BJ_BNE  = 1;
  localparam int BJ_BLT  = 2;
  localparam int BJ_BGE  = 3;
  localparam int BJ_BLTU = 4;
  localparam int BJ_BGEU = 5;
  localparam int BJ_JALR = 6;
  localparam int BJ_JAL  = 7;

  typedef struct packed {
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  alu;
    logic [XLEN-1:0]  sdata;
    logic [4:0]       rd;
    logic             rd_wen;
    logic [MEM_W-1:0] mem;
  } payload_t;

  localparam int PAYLOAD_W = $bits(payload_t);

  // The ALU raises one flag per branch kind; only the flag of the decoded kind counts.
  function automatic logic bj_taken(input logic [BJ_W-1:0] info, input logic [BJ_W-1:0] data);
    return |(info & data);
  endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic valid/ready buffer, 1-cycle latency. SKID_EN=1: 2 entries, o_ready = ~skid_valid
// (registered, independent of i_ready). SKID_EN=0: 1 entry, o_ready = ~o_valid | i_ready.
module pipe_skid_buf #(
  parameter int W       = 8,
  parameter bit SKID_EN = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_flush,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [W-1:0] i_dat,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [W-1:0] o_dat
);

  logic         r_main_vld;
  logic [W-1:0] r_main_dat;
  logic         w_acc;
  logic         w_del;

  assign o_valid = r_main_vld;
  assign o_dat   = r_main_dat;
  assign w_acc   = i_valid & o_ready;
  assign w_del   = r_main_vld & i_ready;

  generate
    if (SKID_EN) begin : g_skid
      logic         r_skid_vld;
      logic [W-1:0] r_skid_dat;

      assign o_ready = ~r_skid_vld;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_main_vld <= 1'b0;
          r_main_dat <= '0;
          r_skid_vld <= 1'b0;
          r_skid_dat <= '0;
        end else if (i_flush) begin
          r_main_vld <= 1'b0;
          r_skid_vld <= 1'b0;
        end else if (r_skid_vld) begin
          if (w_del) begin
            r_main_dat <= r_skid_dat;
            r_skid_vld <= 1'b0;
          end
        end else if (w_acc && (!r_main_vld || w_del)) begin
          r_main_vld <= 1'b1;
          r_main_dat <= i_dat;
        end else if (w_acc) begin
          // Main is held by a stalled consumer: park the new entry behind it.
          r_skid_vld <= 1'b1;
          r_skid_dat <= i_dat;
        end else if (w_del) begin
          r_main_vld <= 1'b0;
        end
      end
    end else begin : g_single
      assign o_ready = ~r_main_vld | i_ready;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_main_vld <= 1'b0;
          r_main_dat <= '0;
        end else if (i_flush) begin
          r_main_vld <= 1'b0;
        end else if (w_acc) begin
          r_main_vld <= 1'b1;
          r_main_dat <= i_dat;
        end else if (w_del) begin
          r_main_vld <= 1'b0;
        end
      end
    end
  endgenerate

endmodule

// File: rtl/exe_mem_skid.sv
// EXE->MEM registered boundary with branch resolution, 1-cycle redirect pulse and flush.
// EXE_MEM_SKID_EN: 2-entry skid, state-only in_ready; undefined: single entry, in_ready = ~out_valid | out_ready.
module exe_mem_skid
  import exe_mem_skid_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  in_pc,
  input  logic [XLEN-1:0]  in_alu,
  input  logic [XLEN-1:0]  in_target,
  input  logic [4:0]       in_rd,
  input  logic             in_rd_wen,
  input  logic [MEM_W-1:0] in_mem,
  input  logic [XLEN-1:0]  in_sdata,
  input  logic [BJ_W-1:0]  bj_info,
  input  logic [BJ_W-1:0]  bj_data,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_pc,
  output logic [XLEN-1:0]  out_alu,
  output logic [XLEN-1:0]  out_sdata,
  output logic [4:0]       out_rd,
  output logic             out_rd_wen,
  output logic [MEM_W-1:0] out_mem,
  output logic             redirect_valid,
  output logic [XLEN-1:0]  redirect_pc
);

`ifdef EXE_MEM_SKID_EN
  localparam bit SKID_EN = 1'b1;
`else
  localparam bit SKID_EN = 1'b0;
`endif

  payload_t               w_in_pl;
  payload_t               w_out_pl;
  logic [PAYLOAD_W-1:0]   w_out_dat;
  logic                   w_accept;
  logic                   w_redirect;
  logic                   r_redirect_vld;
  logic [XLEN-1:0]        r_redirect_pc;

  assign w_in_pl = '{pc: in_pc, alu: in_alu, sdata: in_sdata, rd: in_rd,
                     rd_wen: in_rd_wen, mem: in_mem};

  pipe_skid_buf #(
    .W       (PAYLOAD_W),
    .SKID_EN (SKID_EN)
  ) u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_flush (flush),
    .i_valid (in_valid),
    .o_ready (in_ready),
    .i_dat   (w_in_pl),
    .o_valid (out_valid),
    .i_ready (out_ready),
    .o_dat   (w_out_dat)
  );

  assign w_out_pl   = payload_t'(w_out_dat);
  assign out_pc     = w_out_pl.pc;
  assign out_alu    = w_out_pl.alu;
  assign out_sdata  = w_out_pl.sdata;
  assign out_rd     = w_out_pl.rd;
  assign out_rd_wen = w_out_pl.rd_wen;
  assign out_mem    = w_out_pl.mem;

  // A taken branch killed by a same-cycle flush must not steer fetch.
  assign w_accept   = in_valid & in_ready;
  assign w_redirect = w_accept & bj_taken(bj_info, bj_data) & ~flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_redirect_vld <= 1'b0;
      r_redirect_pc  <= '0;
    end else begin
      r_redirect_vld <= w_redirect;
      if (w_redirect) begin
        r_redirect_pc <= in_target;
      end
    end
  end

  assign redirect_valid = r_redirect_vld;
  assign redirect_pc    = r_redirect_pc;

endmodule

// File: tb/tb_exe_mem_skid.sv
// Randomized + directed bench for exe_mem_skid against a queue-based reference model.
module tb_exe_mem_skid;
  import exe_mem_skid_pkg::*;

`ifdef EXE_MEM_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [XLEN-1:0]  in_pc;
  logic [XLEN-1:0]  in_alu;
  logic [XLEN-1:0]  in_target;
  logic [4:0]       in_rd;
  logic             in_rd_wen;
  logic [MEM_W-1:0] in_mem;
  logic [XLEN-1:0]  in_sdata;
  logic [BJ_W-1:0]  bj_info;
  logic [BJ_W-1:0]  bj_data;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_pc;
  logic [XLEN-1:0]  out_alu;
  logic [XLEN-1:0]  out_sdata;
  logic [4:0]       out_rd;
  logic             out_rd_wen;
  logic [MEM_W-1:0] out_mem;
  logic             redirect_valid;
  logic [XLEN-1:0]  redirect_pc;

  exe_mem_skid dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_alu(in_alu), .in_target(in_target),
    .in_rd(in_rd), .in_rd_wen(in_rd_wen), .in_mem(in_mem), .in_sdata(in_sdata),
    .bj_info(bj_info), .bj_data(bj_data), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_alu(out_alu), .out_sdata(out_sdata),
    .out_rd(out_rd), .out_rd_wen(out_rd_wen), .out_mem(out_mem),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: an in-order queue of capacity CAP plus the pending redirect.
  payload_t        model_q[$];
  logic [63:0]     got_alu[$];
  logic            exp_rv  = 1'b0;
  logic [XLEN-1:0] exp_rpc = '0;

  always @(negedge clk) begin
    payload_t cur;
    logic     exp_rdy;
    logic     acc;
    logic     del;
    if (!rst_n) begin
      model_q.delete();
      exp_rv  = 1'b0;
      exp_rpc = '0;
    end
    exp_rdy = (CAP == 2) ? (model_q.size() < 2) : (model_q.size() == 0 || out_ready);
    check("out_valid", out_valid, model_q.size() != 0);
    check("in_ready", in_ready, exp_rdy);
    check("redirect_valid", redirect_valid, exp_rv);
    check("redirect_pc", redirect_pc, exp_rpc);
    if (model_q.size() != 0) begin
      check("out_pc", out_pc, model_q[0].pc);
      check("out_alu", out_alu, model_q[0].alu);
      check("out_sdata", out_sdata, model_q[0].sdata);
      check("out_rd", out_rd, model_q[0].rd);
      check("out_rd_wen", out_rd_wen, model_q[0].rd_wen);
      check("out_mem", out_mem, model_q[0].mem);
    end
    if (rst_n) begin
      cur = '{pc: in_pc, alu: in_alu, sdata: in_sdata, rd: in_rd, rd_wen: in_rd_wen, mem: in_mem};
      del = (model_q.size() != 0) && out_ready;
      acc = in_valid && exp_rdy;
      if (del) got_alu.push_back(model_q[0].alu);
      if (flush) begin
        model_q.delete();
        exp_rv = 1'b0;
      end else begin
        if (del) void'(model_q.pop_front());
        if (acc) model_q.push_back(cur);
        exp_rv = acc && ((bj_info & bj_data) != '0);
        if (exp_rv) exp_rpc = in_target;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Holds the request until the cycle it is accepted; returns 1 time unit after that edge.
  task automatic send(input logic [63:0] alu, input logic [63:0] pc, input logic [63:0] tgt,
                      input logic [7:0] info, input logic [7:0] data);
    int   n;
    logic acc;
    in_valid  = 1'b1;
    in_alu    = alu;
    in_pc     = pc;
    in_target = tgt;
    bj_info   = info;
    bj_data   = data;
    in_sdata  = {$urandom, $urandom};
    in_rd     = 5'($urandom);
    in_rd_wen = 1'($urandom);
    in_mem    = 8'($urandom);
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 50) begin
      @(negedge clk);
      #4;
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    check("send_accepted", acc, 1'b1);
    in_valid = 1'b0;
    bj_info  = '0;
    bj_data  = '0;
  endtask

  task automatic single_pass(input string tag);
    out_ready = 1'b1;
    send(64'h1234, 64'h8000_0000, 64'h0, 8'h0, 8'h0);
    #1;
    check({tag, "_out_valid"}, out_valid, 1'b1);
    check({tag, "_out_pc"}, out_pc, 64'h8000_0000);
    check({tag, "_out_alu"}, out_alu, 64'h1234);
    check({tag, "_in_ready"}, in_ready, 1'b1);
    tick();
    check({tag, "_drained"}, out_valid, 1'b0);
  endtask

  initial begin
    rst_n = 1'b1; in_valid = 1'b0; in_pc = '0; in_alu = '0; in_target = '0;
    in_rd = '0; in_rd_wen = 1'b0; in_mem = '0; in_sdata = '0;
    bj_info = '0; bj_data = '0; flush = 1'b0; out_ready = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_redirect_valid", redirect_valid, 1'b0);
    check("rst_redirect_pc", redirect_pc, 64'h0);
    check("rst_out_alu", out_alu, 64'h0);
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    single_pass("sp");

    // Backpressure: three items into a stalled consumer, then release.
    got_alu.delete();
    out_ready = 1'b0;
    fork
      begin
        send(64'd1, 64'h100, 64'h0, 8'h0, 8'h0);
        send(64'd2, 64'h104, 64'h0, 8'h0, 8'h0);
        send(64'd3, 64'h108, 64'h0, 8'h0, 8'h0);
      end
      begin
        repeat (5) tick();
        #1 check("bp_in_ready_full", in_ready, 1'b0);
        #1 out_ready = 1'b1;
        #1 check("bp_in_ready_release", in_ready, CAP == 1);
      end
    join
    repeat (6) tick();
    check("bp_count", got_alu.size(), 3);
    for (int i = 0; i < 3; i++) begin
      if (i < got_alu.size()) check("bp_order", got_alu[i], 64'(i + 1));
    end

    // Branch taken / not taken.
    out_ready = 1'b1;
    send(64'd5, 64'h200, 64'h8000_0100, 8'd1 << BJ_BEQ, 8'd1 << BJ_BEQ);
    #1;
    check("br_taken_valid", redirect_valid, 1'b1);
    check("br_taken_pc", redirect_pc, 64'h8000_0100);
    tick();
    check("br_pulse_end", redirect_valid, 1'b0);
    send(64'd6, 64'h204, 64'h8000_0200, 8'd1 << BJ_BEQ, 8'h0);
    #1;
    check("br_not_taken", redirect_valid, 1'b0);
    check("br_pc_hold", redirect_pc, 64'h8000_0100);
    tick();

    // Flush a full buffer while a taken branch is presented.
    out_ready = 1'b0;
    for (int i = 0; i < CAP; i++) send(64'(7 + i), 64'h300, 64'h0, 8'h0, 8'h0);
    in_valid = 1'b1; in_alu = 64'd20; in_target = 64'h8000_0400;
    bj_info = 8'd1 << BJ_JAL; bj_data = 8'd1 << BJ_JAL;
    out_ready = 1'b1; flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0; bj_info = '0; bj_data = '0;
    #1;
    check("fl_out_valid", out_valid, 1'b0);
    check("fl_in_ready", in_ready, 1'b1);
    check("fl_no_redirect", redirect_valid, 1'b0);

    // Async reset between edges with a redirect and an entry in flight.
    out_ready = 1'b0;
    in_valid = 1'b1; in_alu = 64'd9; in_target = 64'h8000_0500;
    bj_info = 8'd1 << BJ_JAL; bj_data = 8'hff;
    tick();
    #2 rst_n = 1'b0;
    in_valid = 1'b0; bj_info = '0; bj_data = '0;
    #1;
    check("ar_out_valid", out_valid, 1'b0);
    check("ar_in_ready", in_ready, 1'b1);
    check("ar_redirect_valid", redirect_valid, 1'b0);
    check("ar_redirect_pc", redirect_pc, 64'h0);
    check("ar_out_alu", out_alu, 64'h0);
    tick();
    rst_n = 1'b1;
    tick();
    single_pass("ar_sp");

    // Random traffic, checked every cycle by the model.
    for (int c = 0; c < 3000; c++) begin
      tick();
      in_valid  = ($urandom_range(0, 9) < 6);
      out_ready = ($urandom_range(0, 9) < 6);
      flush     = ($urandom_range(0, 19) == 0);
      in_pc     = {$urandom, $urandom};
      in_alu    = {$urandom, $urandom};
      in_target = {$urandom, $urandom};
      in_sdata  = {$urandom, $urandom};
      in_rd     = 5'($urandom);
      in_rd_wen = 1'($urandom);
      in_mem    = 8'($urandom);
      bj_info   = ($urandom_range(0, 2) == 0) ? 8'h0 : (8'd1 << $urandom_range(0, 7));
      bj_data   = 8'($urandom);
    end
    tick();
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1; bj_info = '0;
    repeat (5) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/exe_mem_skid.md
Name: exe_mem_skid

Overview:
- Registered boundary between the execute stage ALU/branch logic and the memory stage.
- Latches the ALU result, PC, destination register info, memory-op info and store data with a valid/ready handshake.
- Uses a 2-entry skid buffer so `in_ready` has no combinational dependence on `out_ready`.
- Resolves the branch/jump condition from `bj_data` and emits a registered redirect to fetch; supports pipeline flush.

Parameters:
- XLEN, 64, datapath width.
- BJ_W, 8, width of `bj_data`/`bj_info` (one-hot branch kind: BEQ, BNE, BLT, BGE, BLTU, BGEU, JALR, JAL).
- MEM_W, 8, width of memory-op info bundle (passed through unmodified).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  execute stage has a valid instruction.
- in_ready  out  1  block can accept this cycle.
- in_pc  in  XLEN  instruction PC.
- in_alu  in  XLEN  ALU result (address, rd value or link base).
- in_target  in  XLEN  branch/jump target computed upstream.
- in_rd  in  5  destination register index.
- in_rd_wen  in  1  destination write enable.
- in_mem  in  MEM_W  memory-op info.
- in_sdata  in  XLEN  store data.
- bj_info  in  BJ_W  one-hot branch kind; all-zero for non-control instructions.
- bj_data  in  BJ_W  per-kind condition flags from the ALU.
- flush  in  1  kill all buffered contents.
- out_valid  out  1  memory stage payload valid.
- out_ready  in  1  memory stage accepts.
- out_pc, out_alu, out_sdata  out  XLEN  registered payload.
- out_rd  out  5  registered payload.
- out_rd_wen  out  1  registered payload.
- out_mem  out  MEM_W  registered payload.
- redirect_valid  out  1  one-cycle pulse: fetch must restart at `redirect_pc`.
- redirect_pc  out  XLEN  redirect target.

Behaviour:
- Storage: main entry (drives `out_*`) plus skid entry, each with a valid bit. Occupancy is 0, 1 or 2.
- Handshake:
  - Accept = `in_valid & in_ready`.
  - Deliver = `out_valid & out_ready`.
  - `in_ready = ~skid_valid`, registered and purely state-based.
- State transitions:
  - EMPTY (occupancy 0): accept loads main.
  - ONE: accept & ~deliver loads skid. Accept & deliver loads main with the new payload. Deliver only goes to EMPTY.
  - TWO: `in_ready = 0`. Deliver moves skid into main in the same edge and goes to ONE.
- Ordering: strict FIFO; payload never reordered or duplicated.
- Latency: accept at edge N gives `out_valid` at N+1 when the buffer was empty.
- Branch resolution:
  - `taken = |(bj_info & bj_data)`, evaluated on the accept cycle.
  - On accept with `taken = 1`, `redirect_valid` pulses for exactly one cycle after the accepting edge.
  - `redirect_pc = in_target`, registered.
  - No redirect when not accepted, even if `in_valid & taken`.
- Flush:
  - Synchronous: at the next edge both valid bits clear, so occupancy goes to 0.
  - An accept in the same cycle is discarded.
  - `redirect_valid` is not suppressed if it is already registered.
  - A taken accept coinciding with flush does not redirect.
- Reset: async assert, rst_n low, forces the following; release is synchronous to clk:
  - `out_valid = 0`.
  - skid valid 0.
  - `in_ready = 1`.
  - `redirect_valid = 0`.
  - `redirect_pc = 0`.
  - All payload registers 0.
  - Reset mid-transfer drops all contents.
- Payload registers load only on their load enables, so X on idle inputs is never propagated.

Optional Feature:
- Macro: EXE_MEM_SKID_EN.
- Defined: 2-entry skid behaviour as above.
- Undefined: single-entry register.
  - `in_ready = ~out_valid | out_ready`, combinational.
  - Accept & deliver in the same cycle replaces the entry.
  - Redirect and flush rules are unchanged.
  - Zero-bubble throughput is preserved; the skid storage is removed.

Decomposition:
- Shared package/defines: BJ bit indices (BEQ..JAL), BJ_W, MEM_W, XLEN, and the payload bundle struct/width constant, so execute and memory stages agree.
- One natural sub-module: `pipe_skid_buf`, a generic parameterised 2-entry valid/ready skid buffer carrying a flat payload vector.
- The top module adds branch resolution, the redirect register and flush.

Test Plan:
- Single pass: `in_valid` for 1 cycle, `in_pc = 0x80000000`, `in_alu = 0x1234`, `out_ready = 1` -> `out_valid` exactly one cycle later with the same payload; `in_ready` stays 1.
- Backpressure: `out_ready = 0`, three back-to-back `in_valid` with alu 1, 2, 3 -> items 1 and 2 accepted, `in_ready = 0` on the third cycle. Release `out_ready` -> out sequence 1, 2, 3 with no loss or duplication.
- Branch: `bj_info = BEQ` one-hot, `bj_data` BEQ bit = 1, `in_target = 0x80000100`, accepted -> `redirect_valid` pulses 1 cycle, `redirect_pc = 0x80000100`. Same with flag 0 -> no pulse.
- Flush with buffer full (2 entries) plus concurrent taken accept -> next cycle `out_valid = 0`, `in_ready = 1`, no redirect.
- Async reset asserted mid-stream between edges -> outputs clear immediately without a clock. After release, first accept behaves as in the single-pass scenario.
- With EXE_MEM_SKID_EN undefined: backpressure scenario -> `in_ready` follows `out_ready` combinationally when `out_valid = 1`; order is preserved.
